// File: rtl/rename_tag_alloc.sv
// Two-wide in-order rename tag allocator: hands out circular PRF tags per group,
// drives the RAT tag-write ports, reclaims tags in order on retire, resets on flush.
module rename_tag_alloc #(
  parameter int unsigned TAG_WIDTH  = 6,
  parameter int unsigned ARCH_REGS  = 32,
  parameter int unsigned PIPE_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         grp_valid_i,
  output logic                         grp_ready_o,
  input  logic [1:0]                   lane_rd_we_i,
  input  logic [$clog2(ARCH_REGS)-1:0] lane_rd0_i,
  input  logic [$clog2(ARCH_REGS)-1:0] lane_rd1_i,
  output logic [TAG_WIDTH-1:0]         lane_tag0_o,
  output logic [TAG_WIDTH-1:0]         lane_tag1_o,
  output logic [1:0]                   rat_we_o,
  output logic [$clog2(ARCH_REGS)-1:0] rat_addr0_o,
  output logic [$clog2(ARCH_REGS)-1:0] rat_addr1_o,
  output logic [TAG_WIDTH-1:0]         rat_tag0_o,
  output logic [TAG_WIDTH-1:0]         rat_tag1_o,
  input  logic [1:0]                   retire_cnt_i,
  output logic [TAG_WIDTH:0]           used_count_o,
  output logic                         err_underflow_o
);

  localparam int unsigned NUM_TAGS = 2 ** TAG_WIDTH;
  localparam int unsigned CW       = TAG_WIDTH + 1;
  localparam int unsigned AW       = CW + 1;

  if (PIPE_WIDTH != 2) begin : g_bad_pipe_width
    $error("rename_tag_alloc: PIPE_WIDTH must be 2");
  end

  logic [TAG_WIDTH-1:0] head_q, head_d;
  logic [TAG_WIDTH-1:0] tail_q, tail_d;
  logic [CW-1:0]        used_q, used_d;
  logic                 err_q, err_d;

  logic [1:0]           need;
  logic [CW-1:0]        free_tags;
  logic                 ready;
  logic                 fire;
  logic [1:0]           need_fired;
  logic [1:0]           ret_req;
  logic [1:0]           ret_eff;
  logic [AW-1:0]        avail;
  logic                 underflow;

  // Readiness looks only at the registered count; same-cycle retires do not help.
  always_comb begin
    need       = 2'({1'b0, lane_rd_we_i[0]} + {1'b0, lane_rd_we_i[1]});
    free_tags  = CW'(NUM_TAGS) - used_q;
    ready      = free_tags >= CW'(need);
    fire       = grp_valid_i & ready & ~flush_i & ~rst;
    need_fired = fire ? need : 2'd0;
    avail      = AW'(used_q) + AW'(need_fired);
    ret_req    = (retire_cnt_i == 2'd3) ? 2'd2 : retire_cnt_i;
    ret_eff    = (AW'(ret_req) > avail) ? avail[1:0] : ret_req;
    underflow  = (retire_cnt_i == 2'd3) | (AW'(retire_cnt_i) > avail);
  end

  // Next-state: flush wins over allocate and retire; head keeps advancing across flushes.
  always_comb begin
    head_d = head_q + TAG_WIDTH'(need_fired);
    tail_d = tail_q + TAG_WIDTH'(ret_eff);
    used_d = CW'(avail - AW'(ret_eff));
    err_d  = err_q | underflow;
    if (flush_i) begin
      head_d = head_q;
      tail_d = head_q;
      used_d = '0;
      err_d  = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      used_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      used_q <= used_d;
      err_q  <= err_d;
    end
  end

  // Tags and RAT writes are combinational from head so the PRF captures them this edge.
  always_comb begin
    lane_tag0_o = head_q;
    lane_tag1_o = lane_rd_we_i[0] ? head_q + TAG_WIDTH'(1) : head_q;
    rat_we_o[0] = fire & lane_rd_we_i[0] & (lane_rd0_i != '0);
    rat_we_o[1] = fire & lane_rd_we_i[1] & (lane_rd1_i != '0);
    rat_addr0_o = lane_rd0_i;
    rat_addr1_o = lane_rd1_i;
    rat_tag0_o  = lane_tag0_o;
    rat_tag1_o  = lane_tag1_o;
  end

  assign grp_ready_o     = ready;
  assign used_count_o    = used_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_rename_tag_alloc.sv
// Bench for rename_tag_alloc (8 tags): queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations and a random phase.
module tb_rename_tag_alloc;

  localparam int TW = 3;
  localparam int NT = 8;

  logic       clk = 1'b0;
  logic       rst, flush, grp_valid, grp_ready;
  logic [1:0] rd_we, rat_we, retire_cnt;
  logic [4:0] rd0, rd1, rat_addr0, rat_addr1;
  logic [TW-1:0] tag0, tag1, rat_tag0, rat_tag1;
  logic [TW:0]   used_count;
  logic          err_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding tags as a FIFO, next tag as a plain counter.
  int q[$];
  int next_tag = 0;
  bit m_err = 1'b0;
  int m_map [32];
  int d_map [32];

  rename_tag_alloc #(.TAG_WIDTH(TW), .ARCH_REGS(32), .PIPE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .grp_valid_i(grp_valid),
    .grp_ready_o(grp_ready), .lane_rd_we_i(rd_we), .lane_rd0_i(rd0),
    .lane_rd1_i(rd1), .lane_tag0_o(tag0), .lane_tag1_o(tag1),
    .rat_we_o(rat_we), .rat_addr0_o(rat_addr0), .rat_addr1_o(rat_addr1),
    .rat_tag0_o(rat_tag0), .rat_tag1_o(rat_tag1), .retire_cnt_i(retire_cnt),
    .used_count_o(used_count), .err_underflow_o(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_need();
    return int'(rd_we[0]) + int'(rd_we[1]);
  endfunction

  function automatic bit m_ready();
    return (NT - q.size()) >= m_need();
  endfunction

  function automatic bit m_fire();
    return grp_valid && !flush && !rst && m_ready();
  endfunction

  // Compare process: outputs are stable mid-cycle, inputs change just after posedge.
  task automatic compare_step();
    int t0, t1, bad;
    logic [1:0] ewe;
    t0 = next_tag % NT;
    t1 = rd_we[0] ? (next_tag + 1) % NT : t0;
    ewe[0] = m_fire() && rd_we[0] && (rd0 != 0);
    ewe[1] = m_fire() && rd_we[1] && (rd1 != 0);
    chk("rat_we", 32'(rat_we), 32'(ewe));
    if (!rst) begin
      chk("grp_ready", 32'(grp_ready), 32'(m_ready()));
      chk("lane_tag0", 32'(tag0), 32'(t0));
      chk("lane_tag1", 32'(tag1), 32'(t1));
      chk("rat_tag0", 32'(rat_tag0), 32'(t0));
      chk("rat_tag1", 32'(rat_tag1), 32'(t1));
      if (ewe[0]) chk("rat_addr0", 32'(rat_addr0), 32'(rd0));
      if (ewe[1]) chk("rat_addr1", 32'(rat_addr1), 32'(rd1));
      chk("used_count", 32'(used_count), 32'(q.size()));
      chk("err_underflow", 32'(err_underflow), 32'(m_err));
      bad = 0;
      for (int i = 0; i < 32; i++) if (m_map[i] != d_map[i]) bad++;
      chk("rat_map_entries_differing", 32'(bad), 32'd0);
    end
    // PRF capture with lane-1-last priority.
    if (rat_we[0] === 1'b1) d_map[rat_addr0] = int'(rat_tag0);
    if (rat_we[1] === 1'b1) d_map[rat_addr1] = int'(rat_tag1);
  endtask

  task automatic model_step();
    bit f;
    int r;
    f = m_fire();
    if (rst) begin
      q.delete();
      next_tag = 0;
      m_err = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (f && rd_we[0]) begin
        q.push_back(next_tag);
        if (rd0 != 0) m_map[rd0] = next_tag;
        next_tag = (next_tag + 1) % NT;
      end
      if (f && rd_we[1]) begin
        q.push_back(next_tag);
        if (rd1 != 0) m_map[rd1] = next_tag;
        next_tag = (next_tag + 1) % NT;
      end
      r = int'(retire_cnt);
      if (r == 3) begin m_err = 1'b1; r = 2; end
      if (r > q.size()) begin m_err = 1'b1; r = q.size(); end
      repeat (r) void'(q.pop_front());
    end
  endtask

  initial forever begin @(negedge clk); compare_step(); end
  initial forever begin @(posedge clk); model_step(); end

  task automatic drive(input logic v, input logic [1:0] we, input int r0, input int r1,
                       input int ret, input logic fl);
    grp_valid = v; rd_we = we; rd0 = 5'(r0); rd1 = 5'(r1);
    retire_cnt = 2'(ret); flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_map[i] = 0; d_map[i] = 0; end
    rst = 1'b1;
    idle();
    do_reset();

    // Reset state
    #2;
    chk("reset_used", 32'(used_count), 32'd0);
    chk("reset_ready", 32'(grp_ready), 32'd1);
    chk("reset_tag0", 32'(tag0), 32'd0);
    chk("reset_tag1", 32'(tag1), 32'd0);
    chk("reset_err", 32'(err_underflow), 32'd0);

    // 1: two-lane group from reset
    drive(1'b1, 2'b11, 5, 7, 0, 1'b0); #2;
    chk("s1_tag0", 32'(tag0), 32'd0);
    chk("s1_tag1", 32'(tag1), 32'd1);
    chk("s1_rat_we", 32'(rat_we), 32'd3);
    tick(); idle(); #2;
    chk("s1_used", 32'(used_count), 32'd2);
    chk("s1_head", 32'(tag0), 32'd2);

    // 2: fill all eight tags, then retire one and reuse tag 0
    do_reset();
    for (int i = 0; i < NT; i++) begin
      drive(1'b1, 2'b01, i + 1, 0, 0, 1'b0); #2;
      chk("s2_fill_tag", 32'(tag0), 32'(i));
      tick();
    end
    drive(1'b1, 2'b01, 3, 0, 0, 1'b0); #2;
    chk("s2_full_used", 32'(used_count), 32'd8);
    chk("s2_full_need1_ready", 32'(grp_ready), 32'd0);
    drive(1'b1, 2'b00, 0, 0, 0, 1'b0); #2;
    chk("s2_full_need0_ready", 32'(grp_ready), 32'd1);
    drive(1'b0, 2'b01, 3, 0, 1, 1'b0); #2;
    chk("s2_retire_same_cycle_ready", 32'(grp_ready), 32'd0);
    tick();
    drive(1'b0, 2'b11, 3, 4, 0, 1'b0); #2;
    chk("s2_used7_need2_ready", 32'(grp_ready), 32'd0);
    drive(1'b1, 2'b01, 3, 0, 0, 1'b0); #2;
    chk("s2_used7_need1_ready", 32'(grp_ready), 32'd1);
    chk("s2_reuse_tag", 32'(tag0), 32'd0);
    tick();

    // 3: wrap from head 7
    do_reset();
    for (int i = 0; i < 7; i++) begin drive(1'b1, 2'b01, 2, 0, 0, 1'b0); tick(); end
    drive(1'b0, 2'b00, 0, 0, 0, 1'b1); tick();
    drive(1'b1, 2'b11, 3, 0, 0, 1'b0); #2;
    chk("s3_tag0", 32'(tag0), 32'd7);
    chk("s3_tag1", 32'(tag1), 32'd0);
    chk("s3_rat_we", 32'(rat_we), 32'd1);
    tick(); idle(); #2;
    chk("s3_used", 32'(used_count), 32'd2);
    chk("s3_head", 32'(tag0), 32'd1);

    // 4: flush beats allocate and retire
    drive(1'b1, 2'b11, 4, 6, 0, 1'b0); tick();
    drive(1'b1, 2'b11, 4, 6, 2, 1'b1); #2;
    chk("s4_used_before", 32'(used_count), 32'd4);
    chk("s4_rat_we", 32'(rat_we), 32'd0);
    tick(); idle(); #2;
    chk("s4_used_after", 32'(used_count), 32'd0);
    chk("s4_err", 32'(err_underflow), 32'd0);
    chk("s4_head_kept", 32'(tag0), 32'd3);

    // 5: underflow is sticky across flush, cleared by rst; retire 3 is illegal
    drive(1'b1, 2'b01, 8, 0, 0, 1'b0); tick();
    drive(1'b0, 2'b00, 0, 0, 2, 1'b0); tick(); idle(); #2;
    chk("s5_used", 32'(used_count), 32'd0);
    chk("s5_err_set", 32'(err_underflow), 32'd1);
    drive(1'b0, 2'b00, 0, 0, 0, 1'b1); tick(); idle(); #2;
    chk("s5_err_after_flush", 32'(err_underflow), 32'd1);
    do_reset(); #2;
    chk("s5_err_after_rst", 32'(err_underflow), 32'd0);
    drive(1'b1, 2'b11, 10, 11, 0, 1'b0); tick();
    drive(1'b0, 2'b00, 0, 0, 3, 1'b0); tick(); idle(); #2;
    chk("s5_ret3_used", 32'(used_count), 32'd0);
    chk("s5_ret3_err", 32'(err_underflow), 32'd1);

    // 6: both lanes write the same rd; lane 1 wins in the map
    drive(1'b1, 2'b11, 9, 9, 0, 1'b0); #2;
    chk("s6_rat_we", 32'(rat_we), 32'd3);
    chk("s6_rat_tag0", 32'(rat_tag0), 32'd2);
    chk("s6_rat_tag1", 32'(rat_tag1), 32'd3);
    tick(); idle(); #2;
    chk("s6_prf_x9", 32'(d_map[9]), 32'd3);

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      logic fl;
      int ret;
      fl  = ($urandom_range(0, 31) == 0);
      ret = $urandom_range(0, 2);
      if ($urandom_range(0, 63) == 0) ret = 3;
      if (fl) ret = 0;
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 31), $urandom_range(0, 31), ret, fl);
      tick();
    end
    rst = 1'b0;
    idle();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
